// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          BUF_DEPTH        = 2;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer of {instr, pc}; flush empties it, push and pop may coincide.
module fetch_buf
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t entries [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = entries[rd_ptr];

  // Credits are counted against buffer space, so a push into a full buffer is a bug.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(push && count == 2'd2)) else $error("fetch buffer overflow");
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, credit-limited imem requests, 2-entry fetch buffer.
// Optional IF_NOP_FILL_EN: drive NOP on o_instr whenever o_valid is low.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               o_imem_req,
  output logic [31:0]        o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [31:0]        i_redirect_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc
);

  logic [31:0]  fetch_pc;
  logic [31:0]  resp_pc;
  logic [1:0]   outstanding;
  logic [1:0]   outstanding_nxt;
  logic [1:0]   drop_cnt;
  logic [1:0]   buf_count;
  logic [31:0]  last_pc;
  logic         buf_valid;
  logic         handshake;
  logic         push;
  logic         pop;
  fetch_entry_t head;
  fetch_entry_t push_data;

  assign buf_valid = (buf_count != 2'd0);

  // Request/grant: a request is accepted in any cycle where req && gnt at the clock edge.
  // Credits = granted-but-unreturned requests plus buffered entries, capped at BUF_DEPTH.
  assign o_imem_req  = rst_n && !i_redirect &&
                       (({1'b0, outstanding} + {1'b0, buf_count}) < 3'(BUF_DEPTH));
  assign o_imem_addr = fetch_pc;
  assign handshake   = o_imem_req && i_imem_gnt;

  assign outstanding_nxt = outstanding + {1'b0, handshake} - {1'b0, i_imem_rvalid};

  assign push      = i_imem_rvalid && (drop_cnt == 2'd0) && !i_redirect;
  assign pop       = buf_valid && !i_stall && !i_redirect;
  assign push_data = '{instr: i_imem_rdata, pc: resp_pc};

  fetch_buf u_fetch_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (i_redirect),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .count     (buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      drop_cnt    <= 2'd0;
      last_pc     <= RESET_PC;
    end else begin
      outstanding <= outstanding_nxt;
      if (i_redirect) begin
        // Every request still in flight after this edge belongs to the old stream.
        fetch_pc <= word_align(i_redirect_pc);
        resp_pc  <= word_align(i_redirect_pc);
        drop_cnt <= outstanding_nxt;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + 32'd4;
        if (i_imem_rvalid) begin
          if (drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
          else                  resp_pc  <= resp_pc + 32'd4;
        end
      end
      if (buf_valid) last_pc <= head.pc;
    end
  end

  assign o_valid = buf_valid;
  assign o_pc    = buf_valid ? head.pc : last_pc;

`ifdef IF_NOP_FILL_EN
  assign o_instr = buf_valid ? head.instr : NOP_INSTR;
`else
  logic [INSTR_W-1:0] last_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_instr <= '0;
    else if (buf_valid) last_instr <= head.instr;
  end

  assign o_instr = buf_valid ? head.instr : last_instr;
`endif

endmodule
